// File: rtl/controller_mc2.sv
// Multi-cycle control FSM for the 16-bit CISC datapath: memory ready handshake with
// wait-state timeout, HALT, and a FAULT trap that resume clears.
//
// state         | meaning
// S_FETCH       | read instruction from memory at PC, wait for mem_ready
// S_DECODE      | pick the execution path from the decoder class flags
// S_ARITH_READ1 | rs1 -> TR1
// S_ARITH_READ2 | rs2 -> TR2
// S_ARITH_EXEC  | ALU result -> rd, update flags
// S_IMM_READ    | rd -> TR1
// S_IMM_EXEC    | ALU (immediate op) result -> rd, update flags
// S_LOAD_WAIT   | memory read into rd, wait for mem_ready
// S_STORE_WAIT  | rs2 written to memory, wait for mem_ready
// S_JUMP_EXEC   | load PC if the jump is taken
// S_HALT        | stopped until resume
// S_FAULT       | trapped (timeout or illegal instruction) until resume
module controller_mc2 #(
    parameter int RA_W    = 3,
    parameter int OP_W    = 5,
    parameter int TO_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic [RA_W-1:0] rd,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    input  logic            is_arithmetic,
    input  logic            is_immediate,
    input  logic            is_load,
    input  logic            is_store,
    input  logic            is_jump_unconditional,
    input  logic            is_jump_conditional,
    input  logic            is_halt,
    input  logic            zero_flag,
    input  logic            carry_flag,
    input  logic            mem_ready,
    input  logic            resume,
    output logic            mem_req,
    output logic            mem_write,
    output logic            mem_addr_sel,
    output logic            PC_L,
    output logic            PC_I,
    output logic            IR_L,
    output logic [RA_W-1:0] rf_addr,
    output logic            R_L,
    output logic            R_E,
    output logic [2:0]      AL_S,
    output logic            TR1_L,
    output logic            TR2_L,
    output logic            flag_load,
    output logic [1:0]      data_bus_sel,
    output logic            halted,
    output logic            fault,
    output logic [1:0]      fault_code
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_ARITH_READ1, S_ARITH_READ2, S_ARITH_EXEC,
        S_IMM_READ, S_IMM_EXEC, S_LOAD_WAIT, S_STORE_WAIT, S_JUMP_EXEC,
        S_HALT, S_FAULT
    } state_t;

    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b01001);
    localparam logic [OP_W-1:0] OP_IMM0 = OP_W'(5'b01100);
    localparam logic [OP_W-1:0] OP_IMM1 = OP_W'(5'b01101);
    localparam logic [OP_W-1:0] OP_IMM2 = OP_W'(5'b01110);
    localparam logic [OP_W-1:0] OP_IMM3 = OP_W'(5'b01111);
    localparam logic [OP_W-1:0] OP_JNC  = OP_W'(5'b10100);
    localparam logic [OP_W-1:0] OP_JZ   = OP_W'(5'b10101);
    localparam logic [OP_W-1:0] OP_JNZ  = OP_W'(5'b10110);
    localparam logic [OP_W-1:0] OP_JC   = OP_W'(5'b10111);

    localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);
    localparam logic            TO_EN  = (TIMEOUT != 0);

    state_t          r_state;
    logic [TO_W-1:0] r_wait_cnt;
    logic            r_halted;
    logic            r_fault;
    logic [1:0]      r_fault_code;
    logic            w_timeout;

    // mem_ready in the timeout cycle takes precedence over the fault
    assign w_timeout = TO_EN && (r_wait_cnt == TO_VAL) && !mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_FETCH;
            r_wait_cnt   <= '0;
            r_halted     <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
        end else begin
            r_wait_cnt <= '0;
            case (r_state)
                S_FETCH, S_LOAD_WAIT, S_STORE_WAIT: begin
                    if (mem_ready) begin
                        r_state <= (r_state == S_FETCH) ? S_DECODE : S_FETCH;
                    end else if (w_timeout) begin
                        r_state      <= S_FAULT;
                        r_fault      <= 1'b1;
                        r_fault_code <= 2'b01;
                    end else begin
                        r_wait_cnt <= (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + TO_W'(1);
                    end
                end
                S_DECODE: begin
                    if (is_arithmetic)                                   r_state <= S_ARITH_READ1;
                    else if (is_immediate)                               r_state <= S_IMM_READ;
                    else if (is_load)                                    r_state <= S_LOAD_WAIT;
                    else if (is_store)                                   r_state <= S_STORE_WAIT;
                    else if (is_jump_unconditional || is_jump_conditional) r_state <= S_JUMP_EXEC;
                    else if (is_halt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state      <= S_FAULT;
                        r_fault      <= 1'b1;
                        r_fault_code <= 2'b10;
                    end
                end
                S_ARITH_READ1: r_state <= S_ARITH_READ2;
                S_ARITH_READ2: r_state <= S_ARITH_EXEC;
                S_IMM_READ:    r_state <= S_IMM_EXEC;
                S_ARITH_EXEC, S_IMM_EXEC, S_JUMP_EXEC: r_state <= S_FETCH;
                S_HALT: begin
                    if (resume) begin
                        r_state  <= S_FETCH;
                        r_halted <= 1'b0;
                    end
                end
                S_FAULT: begin
                    if (resume) begin
                        r_state      <= S_FETCH;
                        r_fault      <= 1'b0;
                        r_fault_code <= 2'b00;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign halted     = r_halted;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

    // Strobes are qualified by reset so an access aborted by reset never completes
    always_comb begin
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        mem_addr_sel = 1'b0;
        PC_L         = 1'b0;
        PC_I         = 1'b0;
        IR_L         = 1'b0;
        rf_addr      = '0;
        R_L          = 1'b0;
        R_E          = 1'b0;
        AL_S         = 3'b000;
        TR1_L        = 1'b0;
        TR2_L        = 1'b0;
        flag_load    = 1'b0;
        data_bus_sel = 2'b00;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_req      = 1'b1;
                    data_bus_sel = 2'b01;
                    IR_L         = mem_ready;
                    PC_I         = mem_ready;
                end
                S_ARITH_READ1, S_IMM_READ: begin
                    rf_addr      = (r_state == S_IMM_READ) ? rd : rs1;
                    R_E          = 1'b1;
                    TR1_L        = 1'b1;
                    data_bus_sel = 2'b10;
                end
                S_ARITH_READ2: begin
                    rf_addr      = rs2;
                    R_E          = 1'b1;
                    TR2_L        = 1'b1;
                    data_bus_sel = 2'b10;
                end
                S_ARITH_EXEC: begin
                    AL_S      = (opcode == OP_SUB) ? 3'b001 : 3'b000;
                    rf_addr   = rd;
                    R_L       = 1'b1;
                    flag_load = 1'b1;
                end
                S_IMM_EXEC: begin
                    case (opcode)
                        OP_IMM0: AL_S = 3'b010;
                        OP_IMM1: AL_S = 3'b011;
                        OP_IMM2: AL_S = 3'b100;
                        OP_IMM3: AL_S = 3'b101;
                        default: AL_S = 3'b010;
                    endcase
                    rf_addr   = rd;
                    R_L       = 1'b1;
                    flag_load = 1'b1;
                end
                S_LOAD_WAIT: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    rf_addr      = rd;
                    data_bus_sel = 2'b01;
                    R_L          = mem_ready;
                end
                S_STORE_WAIT: begin
                    mem_req      = 1'b1;
                    mem_write    = 1'b1;
                    mem_addr_sel = 1'b1;
                    rf_addr      = rs2;
                    R_E          = 1'b1;
                    data_bus_sel = 2'b10;
                end
                S_JUMP_EXEC: begin
                    if (is_jump_unconditional) begin
                        PC_L = 1'b1;
                    end else if (is_jump_conditional) begin
                        case (opcode)
                            OP_JZ:   PC_L = zero_flag;
                            OP_JNZ:  PC_L = !zero_flag;
                            OP_JC:   PC_L = carry_flag;
                            OP_JNC:  PC_L = !carry_flag;
                            default: PC_L = 1'b0;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/controller_mc2.md
Name: controller_mc2

Overview:
- Second-generation multi-cycle control FSM for the 16-bit CISC datapath, a drop-in successor to the current controller.
- Adds a memory ready handshake with wait states, a per-access timeout, HALT, and a FAULT trap with resume.
- Register-address and opcode widths are parametrised.
- Sits between the instruction decoder and the datapath (PC, IR, register file, TR1/TR2, ALU, flags, data-bus mux).

Parameters:
RA_W, 3, register address width (rd/rs1/rs2/rf_addr)
OP_W, 5, opcode width; opcode constants compared zero-extended to OP_W
TO_W, 4, width of memory wait counter
TIMEOUT, 15, max wait cycles per memory access before fault; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  OP_W  decoded opcode
rd, rs1, rs2  in  RA_W each  register fields
is_arithmetic, is_immediate, is_load, is_store, is_jump_unconditional, is_jump_conditional, is_halt  in  1 each  decoder class flags
zero_flag, carry_flag  in  1  ALU flags
mem_ready  in  1  memory completes current access this cycle
resume  in  1  leave HALT/FAULT
mem_req  out  1  memory access request
mem_write  out  1  write qualifier, valid with mem_req
mem_addr_sel  out  1  0=PC, 1=instruction address field
PC_L, PC_I, IR_L  out  1  PC load, PC increment, IR load
rf_addr  out  RA_W  register address
R_L, R_E  out  1  register load, register read enable
AL_S  out  3  ALU select
TR1_L, TR2_L  out  1  temp register loads
flag_load  out  1  flag update
data_bus_sel  out  2  00=ALU, 01=memory, 10=register file
halted  out  1  registered, high in HALT
fault  out  1  registered, high in FAULT
fault_code  out  2  registered: 00 none, 01 memory timeout, 10 illegal instruction

Behaviour:
Reset:
- reset=0 forces state=FETCH, wait counter=0, halted=0, fault=0, fault_code=00.
- While reset=0, all combinational outputs are 0 regardless of state.

Outputs:
- Control outputs are combinational from state and inputs.
- Default is all 0, rf_addr=0, AL_S=000, data_bus_sel=00.

FETCH:
- mem_req=1, mem_addr_sel=0, data_bus_sel=01.
- IR_L and PC_I are asserted only in the cycle mem_ready=1, then go to DECODE.
- Otherwise stay in FETCH.

DECODE:
- No outputs.
- Next-state priority: arithmetic>ARITH_READ1, immediate>IMM_READ, load>LOAD_WAIT, store>STORE_WAIT, either jump>JUMP_EXEC, is_halt>HALT.
- No flag set: FAULT with code 10.

ARITH_READ1: rf_addr=rs1, R_E=1, TR1_L=1, bus=10, then ARITH_READ2.

ARITH_READ2: same with rs2 and TR2_L, then ARITH_EXEC.

ARITH_EXEC:
- AL_S=000 for opcode 01000, 001 for 01001, else 000.
- rf_addr=rd, R_L=1, flag_load=1, bus=00, then FETCH.

IMM_READ: rd into TR1 (as ARITH_READ1), then IMM_EXEC.

IMM_EXEC:
- AL_S: 01100>010, 01101>011, 01110>100, 01111>101, else 010.
- rf_addr=rd, R_L=1, flag_load=1, then FETCH.

LOAD_WAIT:
- mem_req=1, mem_addr_sel=1, rf_addr=rd, bus=01.
- R_L=1 only in the cycle mem_ready=1, then FETCH.

STORE_WAIT:
- mem_req=1, mem_write=1, mem_addr_sel=1, rf_addr=rs2, R_E=1, bus=10.
- All held until mem_ready=1, then FETCH.

JUMP_EXEC:
- PC_L=1 if unconditional.
- Conditional cases: 10101 if Z, 10110 if !Z, 10111 if C, 10100 if !C; other opcodes give no jump.
- Then FETCH.

Wait counter:
- Cleared on entry to FETCH, LOAD_WAIT and STORE_WAIT.
- Increments each wait-state cycle with mem_ready=0, saturating at 2^TO_W-1.
- If TIMEOUT!=0, the counter equals TIMEOUT and mem_ready=0, go to FAULT with code 01.
- mem_ready=1 in that same cycle wins: normal completion.
- TIMEOUT must be ≤ 2^TO_W-1.

HALT:
- halted=1 from the cycle after entry; no strobes.
- resume=1 gives FETCH with halted cleared on that edge.

FAULT:
- fault=1 and fault_code held; no strobes; mem_req=0 immediately.
- resume=1 gives FETCH, clearing fault and fault_code.

resume is ignored in all other states.

Asynchronous reset mid-access (any wait state) aborts immediately; no strobe completes.

Latency with mem_ready tied high: ALU op 5 cycles, immediate 4, load/store/jump 3.

Test Plan:
- mem_ready=1, ADD (opcode 01000, rs1=1, rs2=2, rd=3) -> over 5 cycles: TR1_L with rf_addr=1, TR2_L with rf_addr=2, R_L+flag_load with rf_addr=3 and AL_S=000, return to FETCH.
- FETCH with mem_ready low 3 cycles then high -> mem_req high 4 cycles; IR_L and PC_I pulse only on 4th cycle.
- STORE with mem_ready never high, TIMEOUT=15 -> mem_req+mem_write held 16 cycles, then fault=1 and fault_code=01; resume pulse -> FETCH, fault=0.
- mem_ready asserted exactly in the timeout cycle -> normal completion, fault stays 0.
- JNZ (10110) with zero_flag=1 -> PC_L=0; with zero_flag=0 -> PC_L=1 for one cycle.
- Other cases:
  - No decoder flag -> fault_code=10.
  - is_halt -> halted=1; resume while not halted has no effect.
  - reset low mid LOAD_WAIT -> all outputs 0 at once; FETCH after release.
